// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding, default sizes and config-check limits for the conv layer controller
package cnn_ctrl_pkg;
  localparam int DEF_ARRAY_SIZE = 9;
  localparam int DEF_DIM_DATA_SIZE = 16;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_CH_W = 8;
  localparam logic [31:0] MIN_K = 32'd1;
  localparam logic [31:0] MIN_CHANNELS = 32'd1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_FILL_RST = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  function automatic logic cfg_reject(
    input logic [31:0] k,
    input logic [31:0] h,
    input logic [31:0] w,
    input logic [31:0] off,
    input logic [31:0] c,
    input int array_size
  );
    return (k < MIN_K) || (k > h) || (k > w) || (off + k * k > $unsigned(array_size)) || (c < MIN_CHANNELS);
  endfunction
endpackage

// File: rtl/conv_addr_stepper.sv
// conv_addr_stepper: per-channel image/kernel base accumulators with wrap-around stepping
module conv_addr_stepper
  import cnn_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] stride_in,
  input  logic [ADDR_W-1:0] kstride_in,
  input  logic [ADDR_W-1:0] image_base,
  input  logic [ADDR_W-1:0] weight_base,
  output logic [ADDR_W-1:0] image_addr,
  output logic [ADDR_W-1:0] weight_addr
);
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] kstride;
  // load captures strides and channel-0 bases; step advances one channel, wrapping modulo 2^ADDR_W
  always_ff @(posedge clk) begin
    if (reset) begin
      stride <= '0;
      kstride <= '0;
      image_addr <= '0;
      weight_addr <= '0;
    end else if (load) begin
      stride <= stride_in;
      kstride <= kstride_in;
      image_addr <= image_base;
      weight_addr <= weight_base;
    end else if (step) begin
      image_addr <= image_addr + stride;
      weight_addr <= weight_addr + kstride;
    end
  end
endmodule

// File: rtl/conv_channel_scheduler.sv
// conv_channel_scheduler: sequences fill and compute for every input channel of one conv layer
module conv_channel_scheduler
  import cnn_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DIM_DATA_SIZE = DEF_DIM_DATA_SIZE,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CH_W = DEF_CH_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIM_DATA_SIZE-1:0] image_height,
  input  logic [DIM_DATA_SIZE-1:0] image_width,
  input  logic [DIM_DATA_SIZE-1:0] weight_size,
  input  logic [CH_W-1:0]          num_channels,
  input  logic [ADDR_W-1:0]        image_base,
  input  logic [ADDR_W-1:0]        weight_base,
  input  logic [7:0]               fifo_offset,
  input  logic                     fill_completed,
  input  logic                     array_done,
  output logic                     fill_reset_n,
  output logic                     fill_enable,
  output logic [ADDR_W-1:0]        fill_initial_address,
  output logic [7:0]               fill_offset,
  output logic [ADDR_W-1:0]        weight_load_address,
  output logic                     array_start,
  output logic                     busy,
  output logic [CH_W-1:0]          channel_idx,
  output logic                     layer_done,
  output logic                     cfg_error
);
  logic [2:0] state;
  logic phase;
  logic [DIM_DATA_SIZE-1:0] h;
  logic [DIM_DATA_SIZE-1:0] w;
  logic [DIM_DATA_SIZE-1:0] k;
  logic [CH_W-1:0] c;
  logic [ADDR_W-1:0] ib;
  logic [ADDR_W-1:0] wb;
  logic reject;
  logic last;
  logic [ADDR_W-1:0] stride_in;
  logic [ADDR_W-1:0] kstride_in;
  // config validation and per-channel strides from the latched copies
  always_comb begin
    reject = cfg_reject(32'(k), 32'(h), 32'(w), 32'(fill_offset), 32'(c), ARRAY_SIZE);
    last = channel_idx == c - CH_W'(1);
    stride_in = ADDR_W'(32'(h) * 32'(w));
    kstride_in = ADDR_W'(32'(k) * 32'(k));
  end
  // phase counts the two FILL_RST cycles and marks the launch cycle of COMPUTE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= 1'b0;
      channel_idx <= '0;
      h <= '0;
      w <= '0;
      k <= '0;
      c <= '0;
      ib <= '0;
      wb <= '0;
      fill_offset <= '0;
    end else begin
      phase <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          h <= image_height;
          w <= image_width;
          k <= weight_size;
          c <= num_channels;
          ib <= image_base;
          wb <= weight_base;
          fill_offset <= fifo_offset;
          channel_idx <= '0;
          state <= S_CHECK;
        end
        S_CHECK: state <= reject ? S_IDLE : S_FILL_RST;
        S_FILL_RST: begin
          phase <= !phase;
          state <= phase ? S_FILL : S_FILL_RST;
        end
        S_FILL: state <= fill_completed ? S_COMPUTE : S_FILL;
        S_COMPUTE: begin
          phase <= 1'b1;
          state <= array_done ? S_NEXT : S_COMPUTE;
        end
        S_NEXT: begin
          channel_idx <= last ? channel_idx : channel_idx + CH_W'(1);
          state <= last ? S_DONE : S_FILL_RST;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // control outputs decoded from state so a reset takes effect on the very next edge
  always_comb begin
    busy = state != S_IDLE;
    fill_reset_n = !(state == S_IDLE || state == S_FILL_RST);
    fill_enable = state == S_FILL;
    array_start = state == S_COMPUTE && !phase;
    layer_done = state == S_DONE;
    cfg_error = state == S_CHECK && reject;
  end
  conv_addr_stepper #(.ADDR_W(ADDR_W)) stepper (
    .clk(clk),
    .reset(reset),
    .load(state == S_CHECK && !reject),
    .step(state == S_NEXT && !last),
    .stride_in(stride_in),
    .kstride_in(kstride_in),
    .image_base(ib),
    .weight_base(wb),
    .image_addr(fill_initial_address),
    .weight_addr(weight_load_address)
  );
endmodule

// File: tb/tb_conv_channel_scheduler.sv
// tb_conv_channel_scheduler: scoreboard bench for the per-channel conv layer scheduler
module tb_conv_channel_scheduler;
  localparam int K_S = 0;
  localparam int K_D = 1;
  localparam int K_E = 2;
  logic clk, reset, start, fill_completed, array_done;
  logic [15:0] image_height, image_width, weight_size;
  logic [7:0] num_channels, fifo_offset, fill_offset, channel_idx;
  logic [13:0] image_base, weight_base, fill_initial_address, weight_load_address;
  logic fill_reset_n, fill_enable, array_start, busy, layer_done, cfg_error;
  typedef struct {
    int kind;
    int idx;
    logic [13:0] img;
    logic [13:0] wgt;
  } evt_t;
  evt_t q[$];
  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_rst = 0;
  int fill_delay = 3;
  int done_delay = 2;
  bit inject_done = 0;

  conv_channel_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .image_height(image_height), .image_width(image_width), .weight_size(weight_size),
    .num_channels(num_channels), .image_base(image_base), .weight_base(weight_base),
    .fifo_offset(fifo_offset), .fill_completed(fill_completed), .array_done(array_done),
    .fill_reset_n(fill_reset_n), .fill_enable(fill_enable),
    .fill_initial_address(fill_initial_address), .fill_offset(fill_offset),
    .weight_load_address(weight_load_address), .array_start(array_start), .busy(busy),
    .channel_idx(channel_idx), .layer_done(layer_done), .cfg_error(cfg_error)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_s(int i, logic [13:0] a, logic [13:0] b);
    q.push_back('{K_S, i, a, b});
  endfunction

  function automatic void push_k(int kind);
    q.push_back('{kind, 0, 14'h0, 14'h0});
  endfunction

  function automatic void check_evt(int kind);
    evt_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d idx=%0d img=%h wgt=%h, expected no event", kind, channel_idx, fill_initial_address, weight_load_address);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == K_S && (e.idx != int'(channel_idx) || e.img != fill_initial_address || e.wgt != weight_load_address))) begin
        errors++;
        $display("FAIL event: got kind=%0d idx=%0d img=%h wgt=%h, expected kind=%0d idx=%0d img=%h wgt=%h",
          kind, channel_idx, fill_initial_address, weight_load_address, e.kind, e.idx, e.img, e.wgt);
      end
    end
  endfunction

  // fill controller / PE array models: fill_completed after fill_delay, array_done done_delay after launch
  initial begin
    int fcnt, dcnt;
    fcnt = 0;
    dcnt = -1;
    fill_completed = 0;
    array_done = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fcnt = 0;
        dcnt = -1;
        fill_completed = 0;
        array_done = 0;
      end else begin
        fcnt = fill_enable ? fcnt + 1 : 0;
        fill_completed = fill_enable && fcnt > fill_delay;
        if (array_start) dcnt = 0;
        else if (dcnt >= 0) dcnt++;
        array_done = inject_done || dcnt == done_delay;
        if (dcnt == done_delay) dcnt = -1;
      end
    end
  end

  // monitor: pops the scoreboard on every output event and checks fill_reset_n pulse width
  initial begin
    bit prev_rn, started;
    int lowrun;
    prev_rn = 0;
    started = 0;
    lowrun = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        started = 0;
        prev_rn = fill_reset_n;
      end else begin
        if (array_start) begin
          n_start++;
          check_evt(K_S);
        end
        if (layer_done) check_evt(K_D);
        if (cfg_error) check_evt(K_E);
        if (!fill_reset_n && prev_rn && busy) begin
          started = 1;
          lowrun = 0;
        end
        if (!fill_reset_n) lowrun++;
        if (fill_reset_n && !prev_rn && started) begin
          chk("fill_reset_n low cycles", 64'(lowrun), 64'd2);
          n_rst++;
          started = 0;
        end
        if (!busy) started = 0;
        prev_rn = fill_reset_n;
      end
    end
  end

  task automatic go(input logic [15:0] h, input logic [15:0] w, input logic [15:0] k, input logic [7:0] c,
                    input logic [13:0] ib, input logic [13:0] wb, input logic [7:0] off,
                    input int fd, input int dd, input bit exp_err, input bit disturb);
    int cyc, first_fe, s0, r0;
    bit fin, fe_prev;
    fill_delay = fd;
    done_delay = dd;
    s0 = n_start;
    r0 = n_rst;
    first_fe = 0;
    fin = 0;
    fe_prev = 0;
    cyc = 0;
    @(negedge clk);
    image_height = h;
    image_width = w;
    weight_size = k;
    num_channels = c;
    image_base = ib;
    weight_base = wb;
    fifo_offset = off;
    start = 1;
    while (!fin && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        image_height = 16'hFFFF;
        image_width = 16'd1;
        weight_size = 16'd1;
        num_channels = 8'd9;
        image_base = 14'h1234;
        weight_base = 14'h2222;
        fifo_offset = 8'd7;
      end
      start = disturb && array_start;
      inject_done = disturb && fill_enable && channel_idx == 8'd1 && !fe_prev;
      fe_prev = fill_enable;
      if (fill_enable && first_fe == 0) first_fe = cyc;
      if (layer_done || cfg_error) fin = 1;
    end
    start = 0;
    inject_done = 0;
    chk("layer finished within bound", 64'(fin), 64'd1);
    if (exp_err) begin
      chk("reject cycle/busy/no fill", {32'(cyc), 7'd0, cfg_error, 7'd0, busy, 16'(first_fe)}, {32'd1, 8'd1, 8'd1, 16'd0});
    end else begin
      chk("start to fill_enable edges", 64'(first_fe), 64'd4);
      chk("busy with layer_done", {busy, layer_done}, 2'b11);
      chk("fill_offset latched", 64'(fill_offset), 64'(off));
      chk("array_start count", 64'(n_start - s0), 64'(c));
      chk("fill_reset_n pulse count", 64'(n_rst - r0), 64'(c));
    end
    @(posedge clk);
    #1;
    chk("idle after layer", {busy, layer_done, cfg_error}, 3'b000);
    if (!exp_err) chk("channel_idx holds", 64'(channel_idx), 64'(c - 8'd1));
  endtask

  initial begin
    int n;
    reset = 1;
    start = 0;
    image_height = 0;
    image_width = 0;
    weight_size = 0;
    num_channels = 0;
    image_base = 0;
    weight_base = 0;
    fifo_offset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset controls", {fill_reset_n, fill_enable, array_start, busy, layer_done, cfg_error}, 6'b0);
    chk("reset idx/addr", {channel_idx, fill_initial_address, weight_load_address, fill_offset}, 44'h0);
    @(negedge clk);
    reset = 0;
    push_s(0, 14'h0100, 14'h0000); push_k(K_D);
    go(5, 5, 3, 1, 14'h0100, 14'h0000, 0, 20, 10, 0, 0);
    push_s(0, 14'h0100, 14'h0000); push_s(1, 14'h0119, 14'h0009); push_s(2, 14'h0132, 14'h0012); push_k(K_D);
    go(5, 5, 3, 3, 14'h0100, 14'h0000, 0, 3, 2, 0, 0);
    push_k(K_E);
    go(5, 5, 4, 1, 14'h0100, 14'h0000, 0, 3, 2, 1, 0);
    push_k(K_E);
    go(5, 5, 6, 1, 14'h0100, 14'h0000, 0, 3, 2, 1, 0);
    push_k(K_E);
    go(5, 5, 3, 0, 14'h0100, 14'h0000, 0, 3, 2, 1, 0);
    push_k(K_E);
    go(5, 5, 3, 1, 14'h0100, 14'h0000, 1, 3, 2, 1, 0);
    push_k(K_E);
    go(5, 5, 0, 1, 14'h0100, 14'h0000, 0, 3, 2, 1, 0);
    push_s(0, 14'h0200, 14'h0040); push_s(1, 14'h0204, 14'h0044); push_k(K_D);
    go(2, 2, 2, 2, 14'h0200, 14'h0040, 5, 0, 1, 0, 0);
    push_s(0, 14'h3FF0, 14'h0010); push_s(1, 14'h0000, 14'h0014); push_k(K_D);
    go(4, 4, 2, 2, 14'h3FF0, 14'h0010, 0, 2, 3, 0, 0);
    push_s(0, 14'h0100, 14'h0000); push_s(1, 14'h0119, 14'h0009); push_k(K_D);
    go(5, 5, 3, 2, 14'h0100, 14'h0000, 0, 1, 0, 0, 0);
    push_s(0, 14'h0100, 14'h0000); push_s(1, 14'h0119, 14'h0009); push_s(2, 14'h0132, 14'h0012); push_k(K_D);
    go(5, 5, 3, 3, 14'h0100, 14'h0000, 0, 3, 2, 0, 1);
    push_s(0, 14'h0100, 14'h0000);
    fill_delay = 3;
    done_delay = 2;
    @(negedge clk);
    image_height = 5;
    image_width = 5;
    weight_size = 3;
    num_channels = 3;
    image_base = 14'h0100;
    weight_base = 14'h0000;
    fifo_offset = 0;
    start = 1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      start = 0;
      n++;
    end while (!(channel_idx == 8'd1 && fill_enable) && n < 500);
    chk("reached channel 1 fill", 64'(n < 500), 64'd1);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("abort controls", {fill_reset_n, fill_enable, array_start, busy, layer_done, cfg_error}, 6'b0);
    chk("abort idx/addr", {channel_idx, fill_initial_address, weight_load_address, fill_offset}, 44'h0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained after abort", 64'(q.size()), 64'd0);
    push_s(0, 14'h0100, 14'h0000); push_k(K_D);
    go(5, 5, 3, 1, 14'h0100, 14'h0000, 0, 4, 3, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_channel_scheduler.md
Name: conv_channel_scheduler

Overview:
- Sequences one convolution layer, channel by channel.
- For each input channel it re-initialises and runs the image FIFO fill controller, then launches the systolic array and waits for it to finish.
- Sits between the top-level layer control (start/config) and the fill controller / PE array, and owns the per-channel address stepping.

Parameters:
- ARRAY_SIZE, 9, PE rows / FIFOs fed by the fill controller.
- DIM_DATA_SIZE, 16, width of the dimension config fields.
- ADDR_W, 14, BRAM address width.
- CH_W, 8, width of the channel count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle layer start; sampled only in IDLE.
- image_height  in  DIM_DATA_SIZE  feature map height.
- image_width  in  DIM_DATA_SIZE  feature map width.
- weight_size  in  DIM_DATA_SIZE  kernel side K.
- num_channels  in  CH_W  input channels C.
- image_base  in  ADDR_W  address of channel 0, pixel (0,0).
- weight_base  in  ADDR_W  address of channel 0 kernel.
- fifo_offset  in  8  first FIFO index used; passed through to the fill controller.
- fill_completed  in  1  level from the fill controller.
- array_done  in  1  one-cycle pulse from the PE array.
- fill_reset_n  out  1  active-low re-init to the fill controller.
- fill_enable  out  1  fill controller enable.
- fill_initial_address  out  ADDR_W  current channel image base.
- fill_offset  out  8  latched fifo_offset.
- weight_load_address  out  ADDR_W  current channel kernel base.
- array_start  out  1  one-cycle compute launch.
- busy  out  1  high outside IDLE.
- channel_idx  out  CH_W  channel in progress.
- layer_done  out  1  one-cycle completion pulse.
- cfg_error  out  1  one-cycle reject pulse.

Behaviour:
- Reset values: fill_reset_n=0, fill_enable=0, array_start=0, busy=0, layer_done=0, cfg_error=0, channel_idx=0, all addresses 0, state=IDLE. Reset mid-layer aborts immediately; no layer_done is issued.
- States: IDLE, CHECK, FILL_RST, FILL, COMPUTE, NEXT, DONE.
- IDLE, start=1: latch all config inputs on that cycle, then go to CHECK. In IDLE, fill_reset_n is held at 0.
- CHECK (1 cycle): reject if any of K=0, K>image_height, K>image_width, fifo_offset+K*K>ARRAY_SIZE, C=0.
  - On reject: cfg_error pulses for 1 cycle, return to IDLE.
  - Otherwise: compute stride = image_height*image_width and kstride = K*K, both truncated to ADDR_W. Load fill_initial_address=image_base and weight_load_address=weight_base. Go to FILL_RST.
- FILL_RST: drive fill_reset_n=0 for exactly 2 cycles, then release it to 1 and go to FILL.
- FILL: fill_enable=1. On the first cycle fill_completed=1 is sampled, drop fill_enable to 0 on the next edge and go to COMPUTE.
- COMPUTE: array_start=1 on the first cycle in the state only, then wait for array_done.
  - array_done arriving in the same cycle as array_start counts.
  - array_done seen while in any other state is ignored.
- NEXT (1 cycle):
  - If channel_idx==C-1, go to DONE.
  - Otherwise channel_idx+1, fill_initial_address+=stride, weight_load_address+=kstride, go to FILL_RST.
  - Address arithmetic wraps modulo 2^ADDR_W; no error is flagged.
- DONE: layer_done=1 for 1 cycle, then IDLE. channel_idx holds its last value until the next start.
- busy=1 in every state except IDLE. start while busy is ignored (not queued).
- Latency, start to first fill_enable: 1 (IDLE) + 1 (CHECK) + 2 (FILL_RST) = fill_enable high on the 4th edge after start.
- Config inputs may change while busy; only latched copies are used.

Decomposition:
- Shared package (cnn_ctrl_pkg): state encoding localparams, the ADDR_W default, and the config-check limits.
- One natural sub-module: conv_addr_stepper. It holds the stride/kstride registers and the two address accumulators, with load/step controls and wrap-around adds, which keeps the FSM purely control.

Test Plan:
- H=W=5, K=3, C=1, offset=0, image_base=0x0100, weight_base=0x0000; fill_completed 20 cycles after fill_enable, array_done 10 cycles after array_start -> exactly one fill_reset_n 2-cycle low, one array_start, layer_done 1 cycle after NEXT, busy falls with layer_done.
- Same config with C=3 -> fill_initial_address sequence 0x0100, 0x0119, 0x0132; weight_load_address 0x0000, 0x0009, 0x0012; channel_idx 0,1,2; three array_start pulses.
- K=4 with offset=0 (16>9), and separately K=6 with H=5 -> cfg_error 1-cycle pulse, busy high only for IDLE→CHECK, no fill_enable.
- image_base=0x3FF0, H=W=4, K=2, C=2 -> second channel address is 0x0000 (wrap), layer completes normally.
- Assert reset during FILL of channel 1 of 3 -> next edge: all outputs at reset values, no layer_done; a fresh start afterwards runs from channel 0.
- Pulse start during COMPUTE, and array_done during FILL -> both ignored; channel sequence and pulse counts unchanged from the baseline run.
